// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO family.
package fifo_pkg;

  localparam int FIFO_DATA_W = 16;
  localparam int FIFO_DEPTH  = 8;

  // FWFT output-stage states
  localparam logic [0:0] OUT_EMPTY = 1'b0;
  localparam logic [0:0] OUT_VALID = 1'b1;

  // Ceiling log2, usable in constant expressions
  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port.
// The array itself is never reset; only the read-data register is, so the
// FIFO output comes up as zero.
module fifo_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  // Array write; a read of the same address returns the old word
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read data holds unless a read is issued
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem[rd_addr];
  end

  // Read-data register
  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with occupancy count, programmable
// almost-full/empty flags, error pulses and optional FWFT read mode.
// All flags are registered from next-state values.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = FIFO_DATA_W,
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter bit FWFT      = 1'b0,
  localparam int ADDR_W   = clog2_f(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              write,
  input  logic              read,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_THRESH);

  logic [ADDR_W-1:0] head_q, head_d, tail_q, tail_d;
  // count_q: words visible to the user (includes the FWFT output word)
  // mem_cnt_q: words still sitting in the array
  logic [ADDR_W:0]   count_q, count_d, mem_cnt_q, mem_cnt_d;
  logic [0:0]        out_state_q, out_state_d;
  logic dout_valid_q, dout_valid_d;
  logic empty_q, empty_d, full_q, full_d;
  logic af_q, af_d, ae_q, ae_d;
  logic ovf_q, ovf_d, unf_q, unf_d;

  logic avail, out_vld, rd_ok, wr_ok, pop;
  logic [DATA_W-1:0] ram_rd_data;

  // Accept decisions; pop is the array read (a user read in standard mode,
  // a prefetch/reload into dout in FWFT mode)
  always_comb begin
    avail   = (mem_cnt_q != '0);
    out_vld = (out_state_q == OUT_VALID);
    if (FWFT) begin
      rd_ok = read & out_vld;
      pop   = avail & (~out_vld | read);
    end else begin
      rd_ok = read & avail;
      pop   = rd_ok;
    end
    wr_ok = write & (~full_q | rd_ok);
  end

  // Next-state: pointers, counts, output stage and registered flags
  always_comb begin
    head_d    = pop   ? head_q + ADDR_W'(1) : head_q;
    tail_d    = wr_ok ? tail_q + ADDR_W'(1) : tail_q;
    mem_cnt_d = mem_cnt_q + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(pop);
    count_d   = count_q + (ADDR_W+1)'(wr_ok) - (ADDR_W+1)'(rd_ok);

    out_state_d = out_state_q;
    if (pop)        out_state_d = OUT_VALID;
    else if (rd_ok) out_state_d = OUT_EMPTY;

    dout_valid_d = FWFT ? (out_state_d == OUT_VALID) : rd_ok;
    empty_d      = FWFT ? ~dout_valid_d : (count_d == '0);
    full_d       = (count_d == DEPTH_C);
    af_d         = (count_d >= AF_C);
    ae_d         = (count_d <= AE_C);
    ovf_d        = write & ~wr_ok;
    unf_d        = read & ~rd_ok;
  end

  // State registers; reset discards all stored words
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      mem_cnt_q    <= '0;
      out_state_q  <= OUT_EMPTY;
      dout_valid_q <= 1'b0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      af_q         <= (AF_THRESH == 0);
      ae_q         <= 1'b1;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      mem_cnt_q    <= mem_cnt_d;
      out_state_q  <= out_state_d;
      dout_valid_q <= dout_valid_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      af_q         <= af_d;
      ae_q         <= ae_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
    end
  end

  fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_ok & ~rst),
    .wr_addr (tail_q),
    .wr_data (din),
    .rd_en   (pop & ~rst),
    .rd_addr (head_q),
    .rd_data (ram_rd_data)
  );

  assign dout         = ram_rd_data;
  assign dout_valid   = dout_valid_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: a standard-mode and an FWFT instance share one
// stimulus stream; queue-based reference models predict every output.
module tb_fifo_sync_param;

  localparam int DW  = 16;
  localparam int DEP = 8;

  logic clk = 1'b0;
  logic rst = 1'b1, write = 1'b0, read = 1'b0;
  logic [DW-1:0] din = '0;

  logic [DW-1:0] s_dout, f_dout;
  logic s_dv, s_empty, s_full, s_af, s_ae, s_ovf, s_unf;
  logic f_dv, f_empty, f_full, f_af, f_ae, f_ovf, f_unf;
  logic [3:0] s_cnt, f_cnt;

  always #5 clk = ~clk;

  fifo_sync_param #(.DATA_W(DW), .DEPTH(DEP), .FWFT(1'b0)) u_std (
    .clk(clk), .rst(rst), .din(din), .write(write), .read(read),
    .dout(s_dout), .dout_valid(s_dv), .empty(s_empty), .full(s_full),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_cnt),
    .overflow(s_ovf), .underflow(s_unf));

  fifo_sync_param #(.DATA_W(DW), .DEPTH(DEP), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(rst), .din(din), .write(write), .read(read),
    .dout(f_dout), .dout_valid(f_dv), .empty(f_empty), .full(f_full),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_cnt),
    .overflow(f_ovf), .underflow(f_unf));

  typedef struct packed {
    logic [DW-1:0] dout;
    logic dv, empty, full, af, ae, ovf, unf;
    logic [3:0] cnt;
  } st_t;

  st_t sq[$], fq[$];          // expected status after each edge
  logic [DW-1:0] sdq[$];      // expected standard-mode read data, in order

  // reference model state
  logic [DW-1:0] m_s[$], m_f[$];
  logic [DW-1:0] s_last, f_out;
  bit f_have;

  int vectors = 0, miscompares = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic st_t occ(input int c);
    st_t e;
    e = '0;
    e.cnt = 4'(c);
    e.full = (c == DEP);
    e.af = (c >= DEP - 2);
    e.ae = (c <= 2);
    e.empty = (c == 0);
    return e;
  endfunction

  // One clock of stimulus: drive at negedge, predict the post-edge state
  task automatic step(input bit wr, input bit rd, input logic [DW-1:0] d, input bit rs);
    st_t es, ef;
    bit rok, wok, pop;
    int c;
    write = wr; read = rd; din = d; rst = rs;
    if (rs) begin
      m_s.delete(); m_f.delete();
      f_have = 0; s_last = '0; f_out = '0;
      es = occ(0); ef = occ(0);
    end else begin
      rok = rd && (m_s.size() > 0);
      wok = wr && ((m_s.size() < DEP) || rok);
      if (rok) begin
        s_last = m_s.pop_front();
        sdq.push_back(s_last);
      end
      if (wok) m_s.push_back(d);
      es = occ(m_s.size());
      es.dv = rok; es.dout = s_last;
      es.ovf = wr && !wok; es.unf = rd && !rok;

      c   = m_f.size() + int'(f_have);
      rok = rd && f_have;
      wok = wr && ((c < DEP) || rok);
      pop = (m_f.size() > 0) && (!f_have || rd);
      if (pop) begin
        f_out = m_f.pop_front();
        f_have = 1;
      end else if (rok) f_have = 0;
      if (wok) m_f.push_back(d);
      ef = occ(m_f.size() + int'(f_have));
      ef.empty = !f_have; ef.dv = f_have; ef.dout = f_out;
      ef.ovf = wr && !wok; ef.unf = rd && !rok;
    end
    sq.push_back(es);
    fq.push_back(ef);
    @(negedge clk);
  endtask

  // Monitor: compare DUT outputs shortly after each edge
  always @(posedge clk) begin
    st_t es, ef;
    #1;
    if (sq.size() > 0) begin
      es = sq.pop_front();
      ef = fq.pop_front();
      chk("std.dout", 32'(s_dout), 32'(es.dout));
      chk("std.dout_valid", 32'(s_dv), 32'(es.dv));
      chk("std.empty", 32'(s_empty), 32'(es.empty));
      chk("std.full", 32'(s_full), 32'(es.full));
      chk("std.almost_full", 32'(s_af), 32'(es.af));
      chk("std.almost_empty", 32'(s_ae), 32'(es.ae));
      chk("std.overflow", 32'(s_ovf), 32'(es.ovf));
      chk("std.underflow", 32'(s_unf), 32'(es.unf));
      chk("std.count", 32'(s_cnt), 32'(es.cnt));
      chk("fwft.dout", 32'(f_dout), 32'(ef.dout));
      chk("fwft.dout_valid", 32'(f_dv), 32'(ef.dv));
      chk("fwft.empty", 32'(f_empty), 32'(ef.empty));
      chk("fwft.full", 32'(f_full), 32'(ef.full));
      chk("fwft.almost_full", 32'(f_af), 32'(ef.af));
      chk("fwft.almost_empty", 32'(f_ae), 32'(ef.ae));
      chk("fwft.overflow", 32'(f_ovf), 32'(ef.ovf));
      chk("fwft.underflow", 32'(f_unf), 32'(ef.unf));
      chk("fwft.count", 32'(f_cnt), 32'(ef.cnt));
    end
    if (s_dv === 1'b1) begin
      if (sdq.size() == 0) chk("std.read_data_unexpected", 32'(s_dout), 32'hFFFF_FFFF);
      else chk("std.read_data", 32'(s_dout), 32'(sdq.pop_front()));
    end
  end

  initial begin
    @(negedge clk);
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);
    step(0, 0, '0, 0);

    // fill 0x11..0x18, then 0x19 overflows
    for (int i = 0; i < 9; i++) step(1, 0, 16'(16'h11 + i), 0);
    // drain 8, then one underflow
    for (int i = 0; i < 8; i++) step(0, 1, '0, 0);
    step(0, 1, '0, 0);
    step(0, 0, '0, 0);

    // count 3, then 20 cycles of simultaneous write+read across wraps
    for (int i = 0; i < 3; i++) step(1, 0, 16'(16'hA0 + i), 0);
    for (int i = 0; i < 20; i++) step(1, 1, 16'(16'hB0 + i), 0);

    // full with read+write together
    for (int i = 0; i < 5; i++) step(1, 0, 16'(16'hC0 + i), 0);
    for (int i = 0; i < 3; i++) step(1, 1, 16'(16'hD0 + i), 0);
    for (int i = 0; i < 8; i++) step(0, 1, '0, 0);

    // empty with read+write together, then read the word back
    step(1, 1, 16'h5A5A, 0);
    step(0, 1, '0, 0);
    step(0, 0, '0, 0);

    // FWFT fall-through from empty, then pop
    step(0, 0, '0, 1);
    step(1, 0, 16'h00AB, 0);
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);
    step(0, 1, '0, 0);
    step(0, 0, '0, 0);

    // reset with 5 words held; old data must not reappear
    for (int i = 0; i < 5; i++) step(1, 0, 16'(16'hE0 + i), 0);
    step(0, 0, '0, 1);
    step(0, 1, '0, 0);
    step(0, 1, '0, 0);
    step(1, 0, 16'h0077, 0);
    step(0, 1, '0, 0);
    step(0, 1, '0, 0);

    // randomized traffic with occasional resets; bias alternates fill/drain
    for (int i = 0; i < 600; i++) begin
      int wp;
      wp = ((i / 50) % 2 == 0) ? 70 : 30;
      step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp),
           16'($urandom), $urandom_range(0, 79) == 0);
    end

    for (int i = 0; i < 3; i++) step(0, 0, '0, 0);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(sq.size() + sdq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised synchronous FIFO; next generation of the team's 16-bit behavioural FIFO.
- Configurable data width and depth.
- Uses the full power-of-two depth; no slot is wasted.
- Adds occupancy count, programmable almost-full/almost-empty flags, overflow/underflow error pulses and an optional first-word-fall-through (FWFT) read mode.
- Sits between producer and consumer logic in the same clock domain on the FPGA.

Parameters:
- DATA_W, 16: data bus width in bits.
- DEPTH, 8: number of entries; power of two, minimum 2.
- ADDR_W, log2(DEPTH): pointer width; derived, never overridden.
- AF_THRESH, DEPTH-2: almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 2: almost_empty asserts when count <= AE_THRESH.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  DATA_W  write data.
- write  in  1  write request.
- read  in  1  read request (FWFT: pop acknowledge).
- dout  out  DATA_W  read data, registered.
- dout_valid  out  1  dout holds a valid word.
- empty  out  1  no word available to read.
- full  out  1  DEPTH words stored.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  ADDR_W+1  words held, 0..DEPTH.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

Behaviour:
- Reset (rst=1 at rising edge) values:
  - Zero: head, tail, count, dout, dout_valid, full, overflow, underflow.
  - One: empty, almost_empty.
  - almost_full = 1 only if AF_THRESH == 0.
  - Memory contents are not cleared.
- Reset applies mid-operation too: all stored data is discarded and no accept occurs in the reset cycle.
- Accept rules, standard mode:
  - rd_ok = read & ~empty.
  - wr_ok = write & (~full | rd_ok).
  - A write into a full FIFO succeeds only when a read is accepted in the same cycle.
- Count update: count_next = count + wr_ok - rd_ok.
  - Pointers are ADDR_W bits and wrap modulo DEPTH naturally.
- Flags are registered and derived from count_next, so they are valid in the cycle after the edge:
  - full = (count == DEPTH)
  - empty = (count == 0)
- Standard read latency: on rd_ok, dout <= mem[head] and dout_valid = 1 for exactly the next cycle; otherwise dout holds its value and dout_valid = 0.
- Simultaneous read+write while empty (standard mode): write accepted, read rejected, underflow pulses; count becomes 1.
- overflow = write & ~wr_ok; underflow = read & ~rd_ok. Each is a pulse for one cycle after the offending edge.
- FWFT mode, output stage has two states:
  - OUT_EMPTY -> OUT_VALID when the memory is non-empty: prefetch mem[head] into dout.
  - OUT_VALID -> OUT_VALID on read with the memory non-empty: reload the next word.
  - OUT_VALID -> OUT_EMPTY on read with the memory empty.
  - In FWFT mode, empty = ~dout_valid, and count includes the word held in dout.
  - Write-to-dout latency from empty: 2 cycles (memory write, then prefetch).
  - read while ~dout_valid is an underflow.
- Both pointers wrap from DEPTH-1 to 0 with no special case. Data order is preserved across wrap.

Decomposition:
- Shared package/header fifo_pkg:
  - log2 constant function.
  - Default DATA_W and DEPTH.
  - FWFT output-state encoding: OUT_EMPTY = 0, OUT_VALID = 1.
- One sub-module, fifo_ram:
  - Simple dual-port array: one write port, one synchronous read port.
  - No reset on the array.
  - Instantiated by fifo_sync_param.

Test Plan:
- Reset then 8 writes 0x11..0x18 (DEPTH=8) -> count 8, full=1, almost_full from the 6th write.
- Further write 0x19 -> overflow pulses once; 0x19 is never read.
- Read 8 while idle -> dout 0x11..0x18 in order, one cycle after each read; empty=1 after the 8th.
- Then one more read -> underflow pulses, dout holds 0x18.
- 20 cycles of continuous write+read from count 3 -> count stays 3; output order is correct across 2+ pointer wraps.
- Full FIFO with read+write together -> both accepted, count stays 8, no overflow.
- Empty FIFO with read+write together -> count 1, underflow=1, next read returns the written word.
- FWFT=1: write 0xAB into empty -> dout=0xAB, dout_valid=1 two cycles later with no read.
- FWFT=1: then read -> empty=1.
- rst asserted with 5 words held -> next cycle count 0, empty=1, dout 0, almost_empty=1; prior data never emerges.
